// File: rtl/div64_32_if.sv
// Handshake and data bundle for the 64/32 divider: operands and start in,
// results and status flags out.
interface div64_32_if;
    logic        start;
    logic        mode;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] d;
    logic [31:0] q;
    logic [31:0] r;
    logic        busy;
    logic        done;
    logic        dz;
    logic        ovf;

    modport master (
        output start, mode, hi, lo, d,
        input  q, r, busy, done, dz, ovf
    );

    modport slave (
        input  start, mode, hi, lo, d,
        output q, r, busy, done, dz, ovf
    );
endinterface

// File: rtl/div64_32.sv
// Sequential 64/32 divider, signed or unsigned, fixed 34-cycle start-to-done latency.
// Restoring radix-2 core on magnitudes, sign and overflow/zero fix-up in a single cycle.
module div64_32 (
    input  logic       clk,
    input  logic       rst,
    div64_32_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    logic [31:0] rem_q, rem_d, quo_q, quo_d, dmag_q, dmag_d, lo_q, lo_d;
    logic        big_q, big_d, mode_q, mode_d, qneg_q, qneg_d, rneg_q, rneg_d;
    logic [31:0] q_q, q_d, r_q, r_d;
    logic        busy_q, busy_d, done_q, done_d, dz_q, dz_d, ovf_q, ovf_d;

    logic [63:0] dvd_in, dvd_mag;
    logic [31:0] d_mag_in;
    logic        dvd_neg, d_neg;
    logic [32:0] trial;
    logic        fits, sovf;

    assign dvd_in   = {bus.hi, bus.lo};
    assign dvd_neg  = bus.mode & bus.hi[31];
    assign d_neg    = bus.mode & bus.d[31];
    assign dvd_mag  = dvd_neg ? (~dvd_in + 64'd1) : dvd_in;
    assign d_mag_in = d_neg ? (~bus.d + 32'd1) : bus.d;

    assign trial = {rem_q, quo_q[31]};
    assign fits  = (trial >= {1'b0, dmag_q});
    // Negative results may reach -2^31, positive ones stop at 2^31-1.
    assign sovf  = qneg_q ? (quo_q > 32'h8000_0000) : quo_q[31];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.start) state_d = CALC;
            CALC:    if (cnt_q == 5'd31) state_d = FIX;
            FIX:     state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        cnt_d  = cnt_q;
        rem_d  = rem_q;
        quo_d  = quo_q;
        dmag_d = dmag_q;
        lo_d   = lo_q;
        big_d  = big_q;
        mode_d = mode_q;
        qneg_d = qneg_q;
        rneg_d = rneg_q;
        q_d    = q_q;
        r_d    = r_q;
        dz_d   = dz_q;
        ovf_d  = ovf_q;
        busy_d = (state_d != IDLE);
        // done trails the DONE state by one edge so it lands after edge N+34
        done_d = (state_q == DONE);
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    mode_d = bus.mode;
                    lo_d   = bus.lo;
                    dmag_d = d_mag_in;
                    rem_d  = dvd_mag[63:32];
                    quo_d  = dvd_mag[31:0];
                    big_d  = (dvd_mag[63:32] >= d_mag_in);
                    qneg_d = dvd_neg ^ d_neg;
                    rneg_d = dvd_neg;
                    cnt_d  = '0;
                end
            end
            CALC: begin
                // remainder stays below 2^32, so 32-bit modular subtract is exact
                rem_d = fits ? (trial[31:0] - dmag_q) : trial[31:0];
                quo_d = {quo_q[30:0], fits};
                cnt_d = cnt_q + 5'd1;
            end
            FIX: begin
                if (dmag_q == '0) begin
                    dz_d  = 1'b1;
                    ovf_d = 1'b0;
                    q_d   = '1;
                    r_d   = lo_q;
                end else if (big_q || (mode_q && sovf)) begin
                    dz_d  = 1'b0;
                    ovf_d = 1'b1;
                    q_d   = '0;
                    r_d   = '0;
                end else begin
                    dz_d  = 1'b0;
                    ovf_d = 1'b0;
                    q_d   = qneg_q ? (~quo_q + 32'd1) : quo_q;
                    r_d   = rneg_q ? (~rem_q + 32'd1) : rem_q;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            rem_q  <= '0;
            quo_q  <= '0;
            dmag_q <= '0;
            lo_q   <= '0;
            big_q  <= 1'b0;
            mode_q <= 1'b0;
            qneg_q <= 1'b0;
            rneg_q <= 1'b0;
            q_q    <= '0;
            r_q    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
            dz_q   <= 1'b0;
            ovf_q  <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            dmag_q <= dmag_d;
            lo_q   <= lo_d;
            big_q  <= big_d;
            mode_q <= mode_d;
            qneg_q <= qneg_d;
            rneg_q <= rneg_d;
            q_q    <= q_d;
            r_q    <= r_d;
            busy_q <= busy_d;
            done_q <= done_d;
            dz_q   <= dz_d;
            ovf_q  <= ovf_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.dz   = dz_q;
    assign bus.ovf  = ovf_q;
endmodule

// File: tb/tb_div64_32.sv
// Bench for div64_32: directed table, reset/restart sequences, random operands
// against an arithmetic reference, and multiply/divide round trips.
module tb_div64_32;
    typedef struct {
        bit          mode;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] d;
        logic [31:0] eq;
        logic [31:0] er;
        bit          edz;
        bit          eovf;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    div64_32_if bus ();

    div64_32 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model(input bit m, input logic [31:0] hi, input logic [31:0] lo,
                         input logic [31:0] d, output logic [31:0] eq,
                         output logic [31:0] er, output bit edz, output bit eovf);
        logic [63:0]        ua, uq, ur;
        logic signed [65:0] sa, sb, sq, sr;
        edz = 1'b0; eovf = 1'b0; eq = '0; er = '0;
        if (d == 32'd0) begin
            edz = 1'b1; eq = '1; er = lo;
        end else if (!m) begin
            ua = {hi, lo};
            uq = ua / {32'd0, d};
            ur = ua % {32'd0, d};
            if (uq > 64'h0000_0000_FFFF_FFFF) eovf = 1'b1;
            else begin eq = uq[31:0]; er = ur[31:0]; end
        end else begin
            sa = $signed({{2{hi[31]}}, hi, lo});
            sb = $signed({{34{d[31]}}, d});
            sq = sa / sb;
            sr = sa % sb;
            if (sq > 66'sd2147483647 || sq < -66'sd2147483648) eovf = 1'b1;
            else begin eq = sq[31:0]; er = sr[31:0]; end
        end
    endtask

    task automatic run_check(input string nm, input bit m, input logic [31:0] hi,
                             input logic [31:0] lo, input logic [31:0] d,
                             input logic [31:0] eq, input logic [31:0] er,
                             input bit edz, input bit eovf);
        int lat;
        @(negedge clk);
        bus.start = 1'b1; bus.mode = m; bus.hi = hi; bus.lo = lo; bus.d = d;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        bus.hi = $urandom; bus.lo = $urandom; bus.d = $urandom; bus.mode = ~m;
        chk({nm, " busy"}, 32'(bus.busy), 32'd1);
        lat = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) begin
                lat = k;
                break;
            end
        end
        chk({nm, " latency"}, lat, 34);
        chk({nm, " q"}, bus.q, eq);
        chk({nm, " r"}, bus.r, er);
        chk({nm, " dz"}, 32'(bus.dz), 32'(edz));
        chk({nm, " ovf"}, 32'(bus.ovf), 32'(eovf));
        @(posedge clk);
        #1;
        chk({nm, " done width"}, 32'(bus.done), 32'd0);
    endtask

    vec_t tbl[14];

    initial begin
        logic [31:0] eq, er, a, b, hi, lo, d;
        bit          edz, eovf, m;
        logic [63:0] p;
        longint      pa, pb;
        int          ndone, first;
        logic [31:0] cq, cr;

        tbl[0]  = '{1'b0, 32'h0,         32'd100,       32'd7,         32'd14,        32'd2,         1'b0, 1'b0};
        tbl[1]  = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'd7,         32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[2]  = '{1'b0, 32'h0,         32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 32'h0,         32'h1234_5678, 32'd0,         32'hFFFF_FFFF, 32'h1234_5678, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 32'd5,         32'h0,         32'd3,         32'd0,         32'd0,         1'b0, 1'b1};
        tbl[5]  = '{1'b1, 32'h0,         32'h8000_0000, 32'd1,         32'd0,         32'd0,         1'b0, 1'b1};
        tbl[6]  = '{1'b1, 32'h8000_0000, 32'h0,         32'h8000_0000, 32'd0,         32'd0,         1'b0, 1'b1};
        tbl[7]  = '{1'b1, 32'h4000_0000, 32'h0,         32'h8000_0000, 32'h8000_0000, 32'd0,         1'b0, 1'b0};
        tbl[8]  = '{1'b0, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[9]  = '{1'b1, 32'h0,         32'd100,       32'hFFFF_FFF9, 32'hFFFF_FFF2, 32'd2,         1'b0, 1'b0};
        tbl[10] = '{1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'hFFFF_FFF9, 32'd14,        32'hFFFF_FFFE, 1'b0, 1'b0};
        tbl[11] = '{1'b1, 32'hFFFF_FFFF, 32'h8000_0000, 32'd1,         32'h8000_0000, 32'd0,         1'b0, 1'b0};
        tbl[12] = '{1'b0, 32'd3,         32'h0,         32'd3,         32'd0,         32'd0,         1'b0, 1'b1};
        tbl[13] = '{1'b0, 32'd2,         32'h0,         32'd3,         32'hAAAA_AAAA, 32'd2,         1'b0, 1'b0};

        // Reset with start held: start must be ignored while rst is high.
        rst = 1'b1;
        bus.start = 1'b1; bus.mode = 1'b0; bus.hi = 32'h0; bus.lo = 32'd100; bus.d = 32'd7;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        @(posedge clk);
        #1;
        chk("reset busy", 32'(bus.busy), 32'd0);
        chk("reset done", 32'(bus.done), 32'd0);
        chk("reset q", bus.q, 32'd0);
        chk("reset r", bus.r, 32'd0);
        chk("reset dz", 32'(bus.dz), 32'd0);
        chk("reset ovf", 32'(bus.ovf), 32'd0);

        for (int i = 0; i < 14; i++)
            run_check($sformatf("vec%0d", i), tbl[i].mode, tbl[i].hi, tbl[i].lo, tbl[i].d,
                      tbl[i].eq, tbl[i].er, tbl[i].edz, tbl[i].eovf);

        // Extra start pulses while busy must not disturb the running division.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b0; bus.hi = 32'h0; bus.lo = 32'd100; bus.d = 32'd7;
        @(posedge clk);
        ndone = 0; first = 0; cq = '0; cr = '0;
        for (int k = 1; k <= 45; k++) begin
            @(negedge clk);
            bus.start = (k == 5 || k == 10);
            if (k >= 5) begin
                bus.mode = 1'b1; bus.hi = 32'h0; bus.lo = 32'd1000; bus.d = 32'd3;
            end
            @(posedge clk);
            #1;
            if (bus.done) begin
                ndone++;
                if (first == 0) begin
                    first = k; cq = bus.q; cr = bus.r;
                end
            end
        end
        chk("restart done count", ndone, 1);
        chk("restart latency", first, 34);
        chk("restart q", cq, 32'd14);
        chk("restart r", cr, 32'd2);

        // Reset in the middle of CALC, with a simultaneous start that must be dropped.
        @(negedge clk);
        bus.start = 1'b1; bus.mode = 1'b1; bus.hi = 32'hFFFF_FFFF; bus.lo = 32'hFFFF_FF9C; bus.d = 32'd7;
        @(posedge clk);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            bus.start = (k == 16);
            rst = (k == 16);
            @(posedge clk);
            #1;
        end
        chk("abort busy", 32'(bus.busy), 32'd0);
        chk("abort done", 32'(bus.done), 32'd0);
        chk("abort q", bus.q, 32'd0);
        chk("abort r", bus.r, 32'd0);
        chk("abort dz", 32'(bus.dz), 32'd0);
        chk("abort ovf", 32'(bus.ovf), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        bus.start = 1'b0;
        ndone = 0; first = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done) ndone++;
            if (bus.busy) first++;
        end
        chk("abort no done", ndone, 0);
        chk("abort idle", first, 0);
        run_check("after abort", 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FF9C, 32'd7,
                  32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);

        // Random operands against the arithmetic reference.
        for (int i = 0; i < 300; i++) begin
            m  = 1'($urandom_range(0, 1));
            lo = $urandom;
            d  = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
            case (i % 4)
                0: hi = $urandom;
                1: hi = (d != 0) ? ($urandom % d) : $urandom;
                2: hi = {32{lo[31]}};
                default: begin
                    d  = $urandom_range(1, 255);
                    hi = {32{lo[31]}} ^ 32'($urandom_range(0, 3));
                end
            endcase
            model(m, hi, lo, d, eq, er, edz, eovf);
            run_check($sformatf("rand%0d", i), m, hi, lo, d, eq, er, edz, eovf);
        end

        // Multiply then divide by the same factor: quotient returns the other factor.
        for (int i = 0; i < 200; i++) begin
            m = 1'($urandom_range(0, 1));
            a = $urandom;
            b = $urandom;
            if (b == 32'd0) b = 32'd1;
            if (m) begin
                pa = longint'($signed(a));
                pb = longint'($signed(b));
                p  = 64'(pa * pb);
            end else begin
                p = {32'd0, a} * {32'd0, b};
            end
            run_check($sformatf("trip%0d", i), m, p[63:32], p[31:0], b, a, 32'd0, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/div64_32.md
DIV64_32 -- requirements
Module: div64_32

Interface
REQ-001 SHALL have ports: clk input 1, rising-edge clock for all state.
REQ-002 SHALL have port: rst input 1, reset; one clock; reset is synchronous and active-high.
REQ-003 SHALL have port: start input 1, request pulse; sampled only in IDLE.
REQ-004 SHALL have port: mode input 1, 1 = signed (two's complement), 0 = unsigned; sampled with start.
REQ-005 SHALL have port: hi input 32, dividend bits [63:32] (same split as the multiplier product output).
REQ-006 SHALL have port: lo input 32, dividend bits [31:0].
REQ-007 SHALL have port: d input 32, divisor.
REQ-008 SHALL have port: q output 32, quotient.
REQ-009 SHALL have port: r output 32, remainder.
REQ-010 SHALL have port: busy output 1, high while a division is in progress.
REQ-011 SHALL have port: done output 1, one-cycle completion pulse.
REQ-012 SHALL have port: dz output 1, divide-by-zero flag, valid with done.
REQ-013 SHALL have port: ovf output 1, quotient-overflow flag, valid with done.

Function
REQ-014 SHALL implement states IDLE, CALC, FIX, DONE; all outputs registered.
REQ-015 IDLE: on start=1, latch {hi,lo}, d, mode; go to CALC; busy=1 from the next cycle.
REQ-016 start while busy=1 SHALL be ignored with no effect on the running operation or latched operands.
REQ-017 CALC SHALL run exactly 32 cycles of restoring (or non-restoring) radix-2 division on operand magnitudes (64-bit dividend magnitude, 32-bit divisor magnitude), counter 0..31, then go to FIX.
REQ-018 FIX SHALL apply sign correction and overflow/zero substitution in one cycle, then go to DONE.
REQ-019 DONE SHALL last one cycle with done=1, busy=0, then return to IDLE.
REQ-020 Latency: start sampled at edge N -> done=1 in the cycle following edge N+34; fixed for all operands including dz/ovf.
REQ-021 q, r, dz, ovf SHALL hold their values from done until the edge that accepts the next start.
REQ-022 Unsigned: q = floor(dividend/d), r = dividend - q*d.
REQ-023 Signed: quotient truncates toward zero; r has the sign of the dividend (or is 0); |r| < |d|.
REQ-024 Divisor 0: dz=1, ovf=0, q=32'hFFFF_FFFF, r=lo.
REQ-025 Unsigned overflow (d!=0, hi >= d): ovf=1, dz=0, q=0, r=0.
REQ-026 Signed overflow (d!=0, true quotient outside -2^31..2^31-1, including magnitude >= 2^32): ovf=1, dz=0, q=0, r=0.
REQ-027 Signed dividend -2^63 and divisor -2^31 SHALL be handled via 64-bit/32-bit unsigned magnitudes without wrap error.
REQ-028 dz and ovf SHALL never be 1 together; both SHALL be 0 for valid results.

Reset
REQ-029 rst=1 at a rising edge SHALL force IDLE, q=0, r=0, busy=0, done=0, dz=0, ovf=0, counter=0.
REQ-030 rst mid-operation SHALL abort without a done pulse; start in the same cycle as rst SHALL be ignored.
REQ-031 First start is accepted on the first edge with rst=0.

Verification
REQ-032 unsigned, hi=0, lo=100, d=7 -> at N+34: q=14, r=2, dz=0, ovf=0, done one cycle.
REQ-033 signed, {hi,lo}=-100 (hi=FFFF_FFFF, lo=FFFF_FF9C), d=7 -> q=FFFF_FFF2, r=FFFF_FFFE.
REQ-034 d=0, lo=1234_5678, either mode -> dz=1, ovf=0, q=FFFF_FFFF, r=1234_5678; unsigned hi=5, d=3 -> ovf=1, q=0, r=0; signed hi=0, lo=8000_0000, d=1 -> ovf=1.
REQ-035 start pulsed at cycles 5 and 10 of an operation -> second start ignored; exactly one done at N+34 with first operands' result.
REQ-036 rst asserted at cycle 15 of CALC -> busy=0, all outputs 0 next cycle, no done; new start afterwards completes with correct result.
REQ-037 Round-trip: LFSR-generated a, b (b!=0) fed through the pipelined multiplier, product {hi,lo} divided by b in matching mode -> q=a, r=0, dz=0, ovf=0 for 10,000 vectors, mismatch counter stays 0.
